simon_button_reader: RTL



---
 rtl/simon_button_reader_pkg.sv | 34 +++
 rtl/simon_button_reader_sync2.sv | 21 ++
 rtl/simon_button_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/simon_button_reader_pkg.sv
// Shared definitions for the Simon button reader: colour codes, timebase and FSM states.
package simon_button_reader_pkg;

  localparam int MILLI_SECOND = 50_000;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: is_onehot = 1'b1;
      default:                            is_onehot = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] v);
    case (v)
      4'b0010: encode = RED;
      4'b0100: encode = YELLOW;
      4'b1000: encode = BLUE;
      default: encode = GREEN;
    endcase
  endfunction

endpackage

// File: rtl/simon_button_reader_sync2.sv
// Single-bit two-flop synchroniser with synchronous reset.
module simon_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/simon_button_reader.sv
// Synchronises, debounces and encodes the four Simon buttons into a press event and held level.
// Macro SIMON_BTN_RELEASE_EVT_EN adds output release_evt ("release" is a reserved word).
//
// state         | meaning
// ST_IDLE       | waiting for exactly one button while enabled
// ST_DB_PRESS   | candidate must stay alone and stable for DEBOUNCE_CYCLES
// ST_HELD       | press accepted, button still down
// ST_DB_RELEASE | candidate must stay released for DEBOUNCE_CYCLES
module simon_button_reader
  import simon_button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = MILLI_SECOND * 10,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_green,
  input  logic       btn_red,
  input  logic       btn_yellow,
  input  logic       btn_blue,
  input  logic       enable,
  output logic [1:0] select,
  output logic       held,
  output logic       press
`ifdef SIMON_BTN_RELEASE_EVT_EN
  ,
  output logic       release_evt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]       cand, cand_nxt, select_nxt;
  logic             press_nxt;
  logic [3:0]       cand_vec;
  logic             cand_bit;
`ifdef SIMON_BTN_RELEASE_EVT_EN
  logic             release_nxt;
`endif

  simon_sync2 u_sync_green  (.clk(clk), .rst(rst), .d(btn_green),  .q(s[0]));
  simon_sync2 u_sync_red    (.clk(clk), .rst(rst), .d(btn_red),    .q(s[1]));
  simon_sync2 u_sync_yellow (.clk(clk), .rst(rst), .d(btn_yellow), .q(s[2]));
  simon_sync2 u_sync_blue   (.clk(clk), .rst(rst), .d(btn_blue),   .q(s[3]));

  assign cand_vec = 4'b0001 << cand;
  assign cand_bit = s[cand];
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign held     = (state == ST_HELD) || (state == ST_DB_RELEASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cand   <= GREEN;
      select <= GREEN;
      press  <= 1'b0;
`ifdef SIMON_BTN_RELEASE_EVT_EN
      release_evt <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cand   <= cand_nxt;
      select <= select_nxt;
      press  <= press_nxt;
`ifdef SIMON_BTN_RELEASE_EVT_EN
      release_evt <= release_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cand_nxt   = cand;
    select_nxt = select;
    press_nxt  = 1'b0;
`ifdef SIMON_BTN_RELEASE_EVT_EN
    release_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (enable && is_onehot(s)) begin
          cand_nxt  = encode(s);
          cnt_nxt   = '0;
          state_nxt = ST_DB_PRESS;
        end
      end
      ST_DB_PRESS: begin
        // Any other button joining, or the candidate dropping, restarts from idle.
        if (!enable || (s != cand_vec)) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          select_nxt = cand;
          press_nxt  = 1'b1;
          state_nxt  = ST_HELD;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (!cand_bit) begin
          cnt_nxt   = '0;
          state_nxt = ST_DB_RELEASE;
        end
      end
      ST_DB_RELEASE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (cand_bit) begin
          state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
`ifdef SIMON_BTN_RELEASE_EVT_EN
          release_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
